mac_bitserial_ctrl: RTL and testbench

- Bit-serial sequencer for the 256-lane 1-bit × 4-bit multiply slice.
- Accepts one vector of multi-bit unsigned activations plus a weight vector, then drives the slice one activation bit-plane per cycle, LSB first.
- Reduces the 256 returned products each cycle and accumulates them shifted by plane index.
- Presents the final dot product on a valid/ready output; sits between the activation buffer and the slice.

---
 rtl/mac_bitserial_ctrl.sv | 91 +++++++++
 tb/tb_mac_bitserial_ctrl.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/mac_bitserial_ctrl.sv
// mac_bitserial_ctrl: bit-serial sequencer feeding a 1-bit x W_BITS multiply slice, LSB plane first.
// Define MAC_BITSERIAL_SIGNED_EN for two's-complement activations (MSB plane subtracted).
module mac_bitserial_ctrl #(
    parameter int N_LANES = 256,
    parameter int IN_BITS = 8,
    parameter int W_BITS  = 4,
    parameter int ACC_W   = 20
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [N_LANES*IN_BITS-1:0]  in_data,
    input  logic [N_LANES*W_BITS-1:0]   in_weight,
    output logic [N_LANES-1:0]          slice_in,
    output logic [N_LANES*W_BITS-1:0]   slice_weight,
    input  logic [N_LANES*W_BITS-1:0]   slice_product,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [ACC_W-1:0]            out_data,
    output logic                        busy
);
    localparam int PW = $clog2(IN_BITS);
    localparam int SW = W_BITS + $clog2(N_LANES);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                       state, state_nx;
    logic [N_LANES*IN_BITS-1:0]   act;
    logic [N_LANES*W_BITS-1:0]    wgt;
    logic [PW-1:0]                plane;
    logic [ACC_W-1:0]             acc;
    logic [SW-1:0]                plane_sum;
    logic [ACC_W-1:0]             term;
    logic                         last;
    logic                         neg;

    assign last = plane == PW'(IN_BITS - 1);
`ifdef MAC_BITSERIAL_SIGNED_EN
    assign neg = last;
`else
    assign neg = 1'b0;
`endif
    assign term         = ACC_W'(plane_sum) << plane;
    assign in_ready     = state == IDLE;
    assign out_valid    = state == DONE;
    assign busy         = state != IDLE;
    assign out_data     = acc;
    assign slice_weight = wgt;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (in_valid) state_nx = RUN;
            RUN:     if (last) state_nx = DONE;
            DONE:    if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        slice_in  = '0;
        plane_sum = '0;
        for (int i = 0; i < N_LANES; i++) begin
            slice_in[i] = state == RUN && act[IN_BITS*i + int'(plane)];
            plane_sum   = plane_sum + SW'(slice_product[W_BITS*i +: W_BITS]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            act   <= '0;
            wgt   <= '0;
            plane <= '0;
            acc   <= '0;
        end else if (state == IDLE && in_valid) begin
            act   <= in_data;
            wgt   <= in_weight;
            plane <= '0;
            acc   <= '0;
        end else if (state == RUN) begin
            plane <= plane + 1'b1;
            acc   <= neg ? acc - term : acc + term;
        end
    end
endmodule

// File: tb/tb_mac_bitserial_ctrl.sv
// tb_mac_bitserial_ctrl: directed test of mac_bitserial_ctrl with a behavioural 1-bit x 4-bit slice.
module tb_mac_bitserial_ctrl;
    localparam int N = 256, IB = 8, WB = 4, AW = 20;
`ifdef MAC_BITSERIAL_SIGNED_EN
    localparam logic [AW-1:0] EXP_FF  = 20'hFF100;
    localparam logic [AW-1:0] EXP_200 = 20'hFFF58;
`else
    localparam logic [AW-1:0] EXP_FF  = 20'd979200;
    localparam logic [AW-1:0] EXP_200 = 20'd600;
`endif

    logic              clk = 0, rst, in_valid, in_ready, out_valid, out_ready, busy;
    logic [N*IB-1:0]   in_data;
    logic [N*WB-1:0]   in_weight, slice_weight, slice_product;
    logic [N-1:0]      slice_in;
    logic [AW-1:0]     out_data;
    int                checks = 0, errors = 0, n;

    mac_bitserial_ctrl dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_weight(in_weight), .slice_in(slice_in),
        .slice_weight(slice_weight), .slice_product(slice_product),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
    );

    always #5 clk = ~clk;

    // Slice model: each lane gates its weight with the current activation bit.
    always_comb
        for (int i = 0; i < N; i++)
            slice_product[WB*i +: WB] = slice_in[i] ? slice_weight[WB*i +: WB] : '0;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input logic [63:0] obs, input logic [63:0] exp, input string tag);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_all(input logic [IB-1:0] a, input logic [WB-1:0] w);
        for (int i = 0; i < N; i++) begin
            in_data[IB*i +: IB]  = a;
            in_weight[WB*i +: WB] = w;
        end
    endtask

    task automatic set_lane(input int l, input logic [IB-1:0] a, input logic [WB-1:0] w);
        in_data[IB*l +: IB]  = a;
        in_weight[WB*l +: WB] = w;
    endtask

    task automatic wait_out(input string tag);
        while (!out_valid && n < 40) begin
            tick;
            n++;
        end
        chk(64'(n), 64'd9, {tag, "_latency"});
    endtask

    task automatic op(input logic [AW-1:0] exp, input string tag);
        in_valid = 1;
        tick;
        in_valid = 0;
        n = 1;
        wait_out(tag);
        chk(64'(out_data), 64'(exp), {tag, "_data"});
        tick;
        chk(64'(in_ready), 64'd1, {tag, "_idle"});
    endtask

    initial begin
        rst = 1; in_valid = 0; out_ready = 1; in_data = '0; in_weight = '0;
        tick;
        tick;
        chk(64'(in_ready), 1, "rst_in_ready");
        chk(64'(out_valid), 0, "rst_out_valid");
        chk(64'(out_data), 0, "rst_out_data");
        chk(64'(busy), 0, "rst_busy");
        chk(64'(slice_in == '0), 1, "rst_slice_in");
        chk(64'(slice_weight == '0), 1, "rst_slice_weight");
        rst = 0;

        set_all(8'h01, 4'hF);
        in_valid = 1;
        tick;
        in_valid = 0;
        chk(64'(slice_in == '1), 1, "plane0_ones");
        chk(64'(busy), 1, "run_busy");
        chk(64'(in_ready), 0, "run_in_ready");
        tick;
        chk(64'(slice_in == '0), 1, "plane1_zero");
        n = 2;
        wait_out("ones");
        chk(64'(out_data), 64'd3840, "ones_data");
        tick;
        chk(64'(in_ready), 1, "ones_idle");

        set_all(8'hFF, 4'hF);
        op(EXP_FF, "ff");

        set_all(0, 0);
        set_lane(0, 8'd200, 4'd3);
        op(EXP_200, "lane0");

        // Stalled output must hold while out_ready is low.
        set_all(0, 0);
        set_lane(5, 8'd7, 4'd9);
        out_ready = 0;
        in_valid = 1;
        tick;
        in_valid = 0;
        n = 1;
        wait_out("stall");
        for (int k = 0; k < 5; k++) begin
            tick;
            chk(64'(out_valid), 1, "stall_valid");
            chk(64'(out_data), 63, "stall_data");
            chk(64'(in_ready), 0, "stall_in_ready");
            chk(64'(busy), 1, "stall_busy");
        end
        out_ready = 1;
        tick;
        chk(64'(in_ready), 1, "release_in_ready");
        chk(64'(out_valid), 0, "release_out_valid");

        set_all(8'h01, 4'h1);
        in_valid = 1;
        tick;
        in_valid = 0;
        tick;
        tick;
        tick;
        rst = 1;
        tick;
        rst = 0;
        chk(64'(in_ready), 1, "abort_in_ready");
        chk(64'(out_valid), 0, "abort_out_valid");
        chk(64'(slice_in == '0), 1, "abort_slice_in");
        chk(64'(busy), 0, "abort_busy");
        op(20'd256, "after_abort");

        // Back-to-back: in_valid held across both operations.
        set_all(8'h01, 4'hF);
        in_valid = 1;
        tick;
        set_all(0, 0);
        set_lane(0, 8'd200, 4'd3);
        n = 1;
        wait_out("b2b_a");
        chk(64'(out_data), 64'd3840, "b2b_a_data");
        n = 0;
        do begin
            tick;
            n++;
        end while (!out_valid && n < 40);
        chk(64'(n), 10, "b2b_period");
        chk(64'(out_data), 64'(EXP_200), "b2b_b_data");
        in_valid = 0;
        tick;
        chk(64'(in_ready), 1, "b2b_idle");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
